// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, the FIFO write side
// and the round-robin packet arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               full;
  logic               wr_en;
  logic [DW-1:0]      wdata;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               err_overlong;

  modport master (
    output req_valid, req_last, req_data, full,
    input  req_ready, wr_en, wdata, grant, busy, err_overlong
  );

  modport slave (
    input  req_valid, req_last, req_data, full,
    output req_ready, wr_en, wdata, grant, busy, err_overlong
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter for the async FIFO write port.
// Holds a grant for a whole packet, throttled by full.
module fifo_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int MAX_PKT = 16
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_PKT + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic            err;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;

  logic [IW-1:0]   sel_idx;
  logic            sel_any;
  logic [IW-1:0]   gidx;
  logic [DW-1:0]   wdata;
  logic [CW-1:0]   cnt_nxt;
  logic            beat;
  logic            last_beat;
  logic            over;
  logic            rel;

  // first valid requester at or above rr_ptr, wrapping
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      int j;
      j = int'(rr_ptr) + off;
      if (j >= NREQ) j = j - NREQ;
      if (!sel_any && bus.req_valid[j]) begin
        sel_any = 1'b1;
        sel_idx = IW'(j);
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = IW'(i);
    end
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) wdata = wdata | bus.req_data[i*DW +: DW];
    end
  end

  assign beat      = (|(grant & bus.req_valid)) & ~bus.full;
  assign last_beat = beat & (|(grant & bus.req_last));
  assign cnt_nxt   = cnt + CW'(1);
  assign over      = beat & ~last_beat & (cnt_nxt == CW'(MAX_PKT));
  assign rel       = last_beat | over;

  assign bus.req_ready    = bus.full ? '0 : grant;
  assign bus.wr_en        = beat;
  assign bus.wdata        = wdata;
  assign bus.grant        = grant;
  assign bus.busy         = busy;
  assign bus.err_overlong = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_any) begin
            grant <= NREQ'(1) << sel_idx;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BURST;
          end
        end
        BURST: begin
          if (beat) cnt <= cnt_nxt;
          if (over) err <= 1'b1;
          if (rel) begin
            grant  <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
            rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin packet arbiter sharing the single write port of the asynchronous FIFO among `NREQ` requesters in the write clock domain. It grants one requester at a time, holds the grant for a whole packet, and throttles transfers against the FIFO `full` flag. Its `wr_en` output drives the write-side gray pointer counter's increment input. Its `wdata` output drives the FIFO memory write data.

## Interface
- `NREQ`, 4: number of requesters, ≥2.
- `DW`, 8: data width per beat.
- `MAX_PKT`, 16: maximum beats per packet before forced release, ≥2.

- `clk`  in  1: write-domain clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: per-requester beat valid.
- `req_last`  in  NREQ: per-requester last-beat marker, qualified by `req_valid`.
- `req_data`  in  NREQ*DW: requester i data occupies bits [i*DW +: DW].
- `req_ready`  out  NREQ: per-requester ready, combinational.
- `full`  in  1: FIFO full flag, already synchronized to `clk`.
- `wr_en`  out  1: FIFO write strobe, combinational.
- `wdata`  out  DW: data of the granted requester, combinational mux.
- `grant`  out  NREQ: one-hot registered grant. All zero when idle.
- `busy`  out  1: high in state BURST, registered.
- `err_overlong`  out  1: sticky flag, set on a forced release.

## Operation
- Reset values: state IDLE, `grant`=0, `busy`=0, `rr_ptr`=0, beat count=0, `err_overlong`=0. With `grant`=0, outputs `req_ready`=0, `wr_en`=0 and `wdata`=0.
- State machine has two states, IDLE and BURST.
- **IDLE**
  - If any `req_valid` bit is set, select the first set index scanning upward from `rr_ptr`, wrapping modulo NREQ.
  - On the next edge, load `grant` with that one-hot index, clear the beat count, and go to BURST.
  - If no `req_valid` bit is set, stay in IDLE.
  - `req_last` is ignored in IDLE.
- **BURST**
  - `req_ready[i]` = `grant[i]` & !`full`.
  - `wr_en` = |(`grant` & `req_valid`) & !`full`.
  - `wdata` = the `req_data` slice of the granted requester; it is 0 when `grant`=0.
  - Each cycle with `wr_en`=1 is one beat, and the beat count increments.
- **Release:**
  - A beat with the granted `req_last`=1 ends the packet.
  - A beat that makes the count equal `MAX_PKT` without `last` forces a release and sets `err_overlong`.
  - On release, the next edge clears `grant`, returns to IDLE, and sets `rr_ptr` = (granted index + 1) mod NREQ.
- **Stalls:**
  - When `full` is high, no beat occurs and the grant is held indefinitely.
  - When the granted `req_valid` drops mid-packet, the grant is held with no timeout. Other requesters stay blocked.
- Requests from non-granted requesters are ignored until IDLE. Their `req_ready` stays 0.
- `err_overlong` clears only on reset.
- Assertion of `rst_n` mid-packet aborts the packet immediately with no write. The partial packet is not tracked.

## Timing
- Grant latency: a request seen in IDLE at edge k produces `grant` and `busy` valid after edge k+1. The first beat can occur in that same cycle.
- Throughput: one beat per cycle while the grant holds, `full`=0 and `req_valid`=1.
- Inter-packet gap: exactly one IDLE cycle between a release and the next grant.
- Minimum `req_valid`-to-`wr_en` delay: 1 cycle.
- `full` reaches `wr_en` combinationally. A beat never occurs in a cycle with `full`=1.
- When `last` and the `MAX_PKT` limit coincide, the packet counts as a normal release and `err_overlong` is not set.

## Test plan
- **Reset check:** assert `rst_n`=0 with all `req_valid`=1 -> `grant`=0, `wr_en`=0, `busy`=0, `err_overlong`=0. Release reset -> `grant`=4'b0001 one cycle later.
- **Round-robin rotation:** NREQ=4, all requesters continuously send 2-beat packets -> grant order 0,1,2,3,0. Each packet gives `wr_en` high 2 cycles, followed by 1 idle cycle.
- **Full throttling:** granted requester 2 sends a 4-beat packet and `full` pulses high on beat 2 for 3 cycles -> `wr_en`=0 and `req_ready[2]`=0 during those 3 cycles. Exactly 4 writes occur, with data in order.
- **Valid gap:** requester 1 drops `req_valid` for 5 cycles mid-packet while requester 3 requests -> `grant` stays 4'b0010 and `req_ready[3]`=0. Requester 3 is granted only after requester 1's `last`.
- **Overlong packet:** requester 0 sends 20 beats without `last`, `MAX_PKT`=16 -> release after beat 16 and `err_overlong`=1 from the next edge onward. On a later `last` at exactly beat 16, the flag does not set on a fresh reset.
- **Reset mid-packet:** assert `rst_n` after beat 3 of a 6-beat packet -> `grant`=0 and `wr_en`=0 asynchronously. After release, arbitration restarts from `rr_ptr`=0.
